// File: rtl/text_pixel_renderer.sv
// text_pixel_renderer: 80x30 text-mode pixel pipeline (text buffer -> char ROM -> RGB444).
// Fixed 3-cycle latency from pixel coordinates/syncs to rgb/hsync_out/vsync_out.
// Optional blinking underline cursor is enabled by defining the CURSOR_EN macro.
module text_pixel_renderer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000
`ifdef CURSOR_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
`ifdef CURSOR_EN
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
`endif
  output logic [11:0] tbuf_addr,
  input  logic [7:0]  tbuf_data,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned COORD_W = 10;
  localparam logic [ADDR_W-1:0]  COLS_A  = ADDR_W'(COLS);
  localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(COLS * 8);
  localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(ROWS * 16);

  logic       in_area_c;

  logic [2:0] x_bit_s1;
  logic [3:0] y_line_s1;
  logic       video_on_s1, in_area_s1, hsync_s1, vsync_s1;

  logic [7:0] pattern_s2;
  logic       inverse_s2;
  logic [2:0] x_bit_s2;
  logic       video_on_s2, in_area_s2, hsync_s2, vsync_s2;

  logic       pix_c;
  logic       cursor_hit_c;
  logic [11:0] rgb_c;

  // Stage 0: cell address from coordinates; outside the text area the address is parked at 0
  always_comb begin
    in_area_c = (pixel_x < X_LIMIT) && (pixel_y < Y_LIMIT);
    tbuf_addr = '0;
    if (in_area_c) begin
      tbuf_addr = ADDR_W'(pixel_y[8:4]) * COLS_A + ADDR_W'(pixel_x[9:3]);
    end
  end

  // Stage 0 -> 1 register: in-cell position, area flag and video/sync controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_bit_s1    <= '0;
      y_line_s1   <= '0;
      video_on_s1 <= 1'b0;
      in_area_s1  <= 1'b0;
      hsync_s1    <= 1'b1;
      vsync_s1    <= 1'b1;
    end else begin
      x_bit_s1    <= pixel_x[2:0];
      y_line_s1   <= pixel_y[3:0];
      video_on_s1 <= video_on;
      in_area_s1  <= in_area_c;
      hsync_s1    <= hsync_in;
      vsync_s1    <= vsync_in;
    end
  end

  // Stage 1: glyph row address; attribute bit 7 is kept out of the ROM address
  always_comb begin
    rom_addr = {tbuf_data[6:0], y_line_s1};
  end

  // Stage 1 -> 2 register: glyph pattern, inverse attribute and controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_s2  <= '0;
      inverse_s2  <= 1'b0;
      x_bit_s2    <= '0;
      video_on_s2 <= 1'b0;
      in_area_s2  <= 1'b0;
      hsync_s2    <= 1'b1;
      vsync_s2    <= 1'b1;
    end else begin
      pattern_s2  <= rom_data;
      inverse_s2  <= tbuf_data[7];
      x_bit_s2    <= x_bit_s1;
      video_on_s2 <= video_on_s1;
      in_area_s2  <= in_area_s1;
      hsync_s2    <= hsync_s1;
      vsync_s2    <= vsync_s1;
    end
  end

`ifdef CURSOR_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] frame_cnt;
  logic               blink_phase;
  logic               vsync_prev;
  logic [6:0]         col_s1, col_s2;
  logic [4:0]         row_s1, row_s2;
  logic [3:0]         y_line_s2;

  // Frame counter advanced on vsync_in falling edges; toggles blink phase on wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_prev  <= 1'b1;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_prev && !vsync_in) begin
        if (frame_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= BLINK_W'(frame_cnt + 1'b1);
        end
      end
    end
  end

  // Cell coordinates and glyph line carried alongside the pixel for the cursor match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1    <= '0;
      row_s1    <= '0;
      col_s2    <= '0;
      row_s2    <= '0;
      y_line_s2 <= '0;
    end else begin
      col_s1    <= pixel_x[9:3];
      row_s1    <= pixel_y[8:4];
      col_s2    <= col_s1;
      row_s2    <= row_s1;
      y_line_s2 <= y_line_s1;
    end
  end

  // Cursor is an underline on glyph lines 14 and 15 during the visible blink phase
  always_comb begin
    cursor_hit_c = blink_phase && (col_s2 == cursor_col) && (row_s2 == cursor_row)
                   && (y_line_s2[3:1] == 3'b111);
  end
`else
  // No cursor in this build
  always_comb begin
    cursor_hit_c = 1'b0;
  end
`endif

  // Stage 2: select the glyph bit (bit 7 is leftmost), apply attribute and cursor, pick colour
  always_comb begin
    pix_c = pattern_s2[~x_bit_s2] ^ inverse_s2 ^ cursor_hit_c;
    rgb_c = 12'h000;
    if (video_on_s2) begin
      if (!in_area_s2) begin
        rgb_c = BG_COLOR;
      end else begin
        rgb_c = pix_c ? FG_COLOR : BG_COLOR;
      end
    end
  end

  // Output register: colour and syncs leave aligned after the third flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= rgb_c;
      hsync_out <= hsync_s2;
      vsync_out <= vsync_s2;
    end
  end

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Bench for text_pixel_renderer: directed vector table, reset/latency sequences,
// and randomized streams checked against a coordinate-level reference model.
module tb_text_pixel_renderer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [11:0] tbuf_addr;
  logic [7:0]  tbuf_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
`ifdef CURSOR_EN
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
`endif

  logic [7:0] tbuf_mem [0:4095];
  logic [7:0] rom_mem  [0:2047];

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int          x;
    int          y;
    logic        von;
    logic [7:0]  ch;
    logic [7:0]  romd;
    logic        wr;
    logic [11:0] e_tbuf;
    logic [10:0] e_rom;
    logic        chk_rom;
    logic [11:0] e_rgb;
  } vec_t;

  always #5 clk = ~clk;

`ifdef CURSOR_EN
  text_pixel_renderer #(.BLINK_FRAMES(2)) dut (
`else
  text_pixel_renderer dut (
`endif
    .clk(clk), .rst(rst),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
`ifdef CURSOR_EN
    .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
    .tbuf_addr(tbuf_addr), .tbuf_data(tbuf_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // External memories: synchronous text buffer, combinational char ROM
  always @(posedge clk) tbuf_data <= tbuf_mem[tbuf_addr];
  assign rom_data = rom_mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference: pixel colour straight from the text-mode rules
  function automatic logic [11:0] ref_rgb(input int x, input int y, input logic von);
    int ch, pat, b;
    if (!von) return 12'h000;
    if (x >= 640 || y >= 480) return BG;
    ch  = int'(tbuf_mem[(y / 16) * 80 + x / 8]);
    pat = int'(rom_mem[(ch % 128) * 16 + y % 16]);
    b   = ((pat >> (7 - x % 8)) & 1) ^ (ch / 128);
    return (b != 0) ? FG : BG;
  endfunction

  // One streamed pixel; compares the output of the pixel applied three edges earlier
  task automatic step(input int x, input int y, input logic von, input logic hs, input logic vs);
    exp_t e;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    e.rgb = ref_rgb(x, y, von);
    e.hs  = hs;
    e.vs  = vs;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("stream_rgb", 32'(rgb), 32'(e.rgb));
      chk("stream_hsync", 32'(hsync_out), 32'(e.hs));
      chk("stream_vsync", 32'(vsync_out), 32'(e.vs));
    end
  endtask

  // Hold one pixel long enough to flush the pipeline, then check its colour
  task automatic hold_check(input int x, input int y, input logic von,
                            input logic [11:0] exp, input string nm);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    repeat (3) @(posedge clk);
    #1;
    chk(nm, 32'(rgb), 32'(exp));
  endtask

  task automatic restart_stream();
    exp_t r;
    r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1;
    q.delete();
    q.push_back(r);
    q.push_back(r);
  endtask

  vec_t vt [11];

  initial begin
    vt[0]  = '{17, 35, 1'b1, 8'h41, 8'h20, 1'b1, 12'd162, 11'h413, 1'b1, 12'h000};
    vt[1]  = '{18, 35, 1'b1, 8'h41, 8'h20, 1'b1, 12'd162, 11'h413, 1'b1, FG};
    vt[2]  = '{18, 35, 1'b1, 8'hC1, 8'h20, 1'b1, 12'd162, 11'h413, 1'b1, 12'h000};
    vt[3]  = '{17, 35, 1'b1, 8'hC1, 8'h20, 1'b1, 12'd162, 11'h413, 1'b1, FG};
    vt[4]  = '{700, 100, 1'b1, 8'h00, 8'h00, 1'b0, 12'd0, 11'h000, 1'b0, BG};
    vt[5]  = '{700, 100, 1'b0, 8'h00, 8'h00, 1'b0, 12'd0, 11'h000, 1'b0, 12'h000};
    vt[6]  = '{639, 479, 1'b1, 8'h7F, 8'h01, 1'b1, 12'd2399, 11'h7FF, 1'b1, FG};
    vt[7]  = '{632, 479, 1'b1, 8'h7F, 8'h01, 1'b1, 12'd2399, 11'h7FF, 1'b1, 12'h000};
    vt[8]  = '{0, 0, 1'b1, 8'h80, 8'h00, 1'b1, 12'd0, 11'h000, 1'b1, FG};
    vt[9]  = '{640, 0, 1'b1, 8'h00, 8'h00, 1'b0, 12'd0, 11'h000, 1'b0, BG};
    vt[10] = '{0, 480, 1'b1, 8'h00, 8'h00, 1'b0, 12'd0, 11'h000, 1'b0, BG};

    for (int i = 0; i < 4096; i++) tbuf_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);

    rst = 1'b1;
    pixel_x = '0; pixel_y = '0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
`ifdef CURSOR_EN
    cursor_col = 7'd127; cursor_row = 5'd31;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", 32'(rgb), 32'h000);
    chk("reset_hsync", 32'(hsync_out), 32'd1);
    chk("reset_vsync", 32'(vsync_out), 32'd1);
    hsync_in = 1'b1;
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) begin
        tbuf_mem[vt[i].e_tbuf] = vt[i].ch;
        rom_mem[vt[i].e_rom]   = vt[i].romd;
      end
      pixel_x  = 10'(vt[i].x);
      pixel_y  = 10'(vt[i].y);
      video_on = vt[i].von;
      #1;
      chk($sformatf("vec%0d_tbuf_addr", i), 32'(tbuf_addr), 32'(vt[i].e_tbuf));
      @(posedge clk); #1;
      if (vt[i].chk_rom) chk($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vt[i].e_rom));
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rgb", i), 32'(rgb), 32'(vt[i].e_rgb));
    end

    // Mid-stream asynchronous reset while driving a lit pixel with hsync low
    tbuf_mem[162] = 8'h41;
    rom_mem[11'h413] = 8'h20;
    hsync_in = 1'b0;
    hold_check(18, 35, 1'b1, FG, "pre_reset_rgb");
    chk("pre_reset_hsync", 32'(hsync_out), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_rgb", 32'(rgb), 32'h000);
    chk("async_reset_hsync", 32'(hsync_out), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    restart_stream();
    for (int i = 0; i < 6; i++) step(18, 35, 1'b1, 1'b0, 1'b1);

    // Scanline sweep across the bottom text rows and into vertical blanking
    for (int y = 476; y < 492; y++) begin
      for (int x = 0; x < 800; x++) begin
        step(x, y, (x < 640) && (y < 480),
             !((x >= 656) && (x < 752)), !((y >= 490) && (y < 492)));
      end
    end

    // Random coordinates and syncs
    for (int i = 0; i < 5000; i++) begin
      step(int'($urandom_range(799)), int'($urandom_range(524)), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

`ifdef CURSOR_EN
    // Cursor blink with a two-frame phase on a blank cell at (col 5, row 3)
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    cursor_col = 7'd5; cursor_row = 5'd3;
    tbuf_mem[3 * 80 + 5] = 8'h00;
    rom_mem[14] = 8'h00;
    rom_mem[15] = 8'h00;
    rom_mem[13] = 8'h00;
    hold_check(40, 62, 1'b1, BG, "cursor_off_start");
    for (int e = 0; e < 2; e++) begin
      vsync_in = 1'b0; @(posedge clk); #1;
      vsync_in = 1'b1; @(posedge clk); #1;
    end
    for (int x = 40; x < 48; x++) hold_check(x, 62, 1'b1, FG, "cursor_on_line14");
    hold_check(47, 63, 1'b1, FG, "cursor_on_line15");
    hold_check(40, 61, 1'b1, BG, "cursor_line13_clear");
    hold_check(48, 62, 1'b1, BG, "cursor_next_cell_clear");
    for (int e = 0; e < 2; e++) begin
      vsync_in = 1'b0; @(posedge clk); #1;
      vsync_in = 1'b1; @(posedge clk); #1;
    end
    hold_check(40, 62, 1'b1, BG, "cursor_off_again");
    hold_check(44, 63, 1'b1, BG, "cursor_off_again_l15");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
